imem_load_controller: RTL and testbench
=======================================

Name: imem_load_controller

Overview:
- Sequences access to the word-aligned instruction memory array.
- Shares the array's single address port between CPU fetch (read) and a byte-stream program loader (write), e.g. a UART bootloader.
- Stalls the CPU while a load is in progress.
- Requests a CPU restart when the load completes.

Parameters:
INSTR_ADDR_BITS, 5, word-address width; memory depth = 2^INSTR_ADDR_BITS words (32 words = 128 bytes)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
pc  input  32  CPU fetch byte address
instruction  output  32  fetched word to CPU
cpu_stall  output  1  high while the loader owns memory
cpu_restart  output  1  one-cycle pulse: CPU must reload pc to 0
load_start  input  1  pulse: begin program load
load_end  input  1  pulse: finish program load
byte_in  input  8  loader data byte
byte_valid  input  1  byte_in valid this cycle; no backpressure
words_loaded  output  INSTR_ADDR_BITS+1  count of words written in the current/last load
load_err  output  1  sticky: last load ended with a partial word or overflowed depth
mem_addr  output  INSTR_ADDR_BITS  word address to memory
mem_wdata  output  32  write data to memory
mem_we  output  1  write enable; memory writes on rising clk
mem_rdata  input  32  combinational read data from memory

Behaviour:
- States: RUN, LOAD, FLUSH. Reset state is RUN.
- Reset values: cpu_stall=0, cpu_restart=0, mem_we=0, mem_wdata=0, words_loaded=0, load_err=0, write pointer=0, byte count=0, assembly register=0.
- RUN:
  - mem_addr = pc[INSTR_ADDR_BITS+1:2]. Low two pc bits are ignored; upper bits wrap.
  - instruction = mem_rdata, combinational, zero latency.
  - cpu_stall=0. byte_valid and load_end are ignored.
  - load_start -> LOAD next cycle. On entry: clear write pointer, byte count, words_loaded and load_err.
- LOAD:
  - cpu_stall=1 (combinational from state). instruction is driven 0.
  - Each byte_valid cycle, byte_in is shifted into the assembly register little-endian: first byte -> [7:0], fourth byte -> [31:24]. Byte count increments mod 4.
  - On the fourth byte: register mem_wdata = assembled word and mem_addr = write pointer, and pulse mem_we for exactly the next cycle. Then increment the write pointer (wraps at 2^INSTR_ADDR_BITS) and increment words_loaded.
  - Back-to-back bytes every cycle are supported; no byte is lost while a write is in flight.
  - A write into word address 2^INSTR_ADDR_BITS or beyond (i.e. write-pointer wrap) sets load_err. words_loaded saturates at 2^INSTR_ADDR_BITS.
  - load_start while in LOAD is ignored.
  - load_end -> FLUSH.
    - If byte_valid occurs in the same cycle, that byte is accepted first (it may complete a word).
    - If byte count is nonzero after that byte, the partial word is discarded and load_err is set.
- FLUSH:
  - Lasts one cycle and lets any pending mem_we complete. cpu_stall=1.
  - Then -> RUN, asserting cpu_restart for exactly the first RUN cycle.
- Reset mid-load: returns to RUN immediately, no further writes, no cpu_restart. Words already written stay in memory.
- mem_addr in LOAD/FLUSH is the registered write address. mem_we is never asserted in RUN.

Decomposition:
- Shared package: state encoding (RUN/LOAD/FLUSH), BYTES_PER_WORD=4, default INSTR_ADDR_BITS.
- One natural sub-module: imem_word_assembler (byte shift register, mod-4 counter, word_valid pulse). The FSM and address mux stay in the top.

Test Plan:
- Reset, then pc=0x0,0x4,0x7C,0x80 with memory preloaded -> instruction equals words 0,1,31,0 (wrap); cpu_stall=0 throughout.
- load_start; bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 on consecutive cycles; load_end -> mem_we pulses twice: addr0=0x00000013, addr1=0x00100093; words_loaded=2, load_err=0; cpu_restart one cycle after FLUSH.
- load_start; 6 bytes then load_end -> one write only; load_err=1; words_loaded=1.
- Load 33 words (132 bytes) -> 33rd word overwrites addr 0; load_err=1; words_loaded=32.
- 4th byte coincident with load_end -> word written, load_err=0, then FLUSH -> RUN.
- reset asserted after 2 of 4 bytes of the 3rd word -> state RUN, cpu_stall=0, no mem_we afterward, cpu_restart never pulses; words 0-1 retain loaded values.

Source files
------------

// File: rtl/imem_load_controller_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Imported by the controller top and its word assembler.
package imem_load_controller_pkg;

    localparam int BYTES_PER_WORD      = 4;
    localparam int DEF_INSTR_ADDR_BITS = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler with a mod-4 byte counter.
// word is valid in the same cycle as the fourth byte.
module imem_word_assembler
    import imem_load_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        partial_next
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt;
    logic [23:0] shreg;
    logic [1:0]  cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            cnt <= cnt + 2'd1;
            unique case (cnt)
                2'd0:    shreg[7:0]   <= byte_in;
                2'd1:    shreg[15:8]  <= byte_in;
                2'd2:    shreg[23:16] <= byte_in;
                default: shreg        <= '0;
            endcase
        end
    end

    // Fourth byte bypasses the register so the word is ready immediately.
    assign word         = {byte_in, shreg};
    assign word_valid   = byte_valid && (cnt == LAST);
    assign cnt_nxt      = byte_valid ? cnt + 2'd1 : cnt;
    assign partial_next = (cnt_nxt != 2'd0);

endmodule

// File: rtl/imem_load_controller.sv
// Arbitrates the instruction memory port between CPU fetch and a
// byte-stream program loader; stalls and restarts the CPU around a load.
module imem_load_controller
    import imem_load_controller_pkg::*;
#(
    parameter int INSTR_ADDR_BITS = DEF_INSTR_ADDR_BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                pc,
    output logic [31:0]                instruction,
    output logic                       cpu_stall,
    output logic                       cpu_restart,
    input  logic                       load_start,
    input  logic                       load_end,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    output logic [INSTR_ADDR_BITS:0]   words_loaded,
    output logic                       load_err,
    output logic [INSTR_ADDR_BITS-1:0] mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       mem_we,
    input  logic [31:0]                mem_rdata
);

    localparam int DEPTH = 2 ** INSTR_ADDR_BITS;
    localparam logic [INSTR_ADDR_BITS:0] WL_MAX = (INSTR_ADDR_BITS + 1)'(DEPTH);

    state_t state, state_nxt;

    logic [INSTR_ADDR_BITS-1:0] wptr;
    logic [INSTR_ADDR_BITS-1:0] waddr_q;
    logic [31:0]                wdata_q;
    logic                       we_q;
    logic                       restart_q;
    logic [INSTR_ADDR_BITS:0]   wl_q;
    logic                       err_q;

    logic [31:0] asm_word;
    logic        asm_word_valid;
    logic        asm_partial;
    logic        in_load;

    logic unused_pc;
    assign unused_pc = ^{pc[31:INSTR_ADDR_BITS+2], pc[1:0]};

    assign in_load = (state == LOAD);

    imem_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear        (!in_load),
        .byte_valid   (byte_valid && in_load),
        .byte_in      (byte_in),
        .word         (asm_word),
        .word_valid   (asm_word_valid),
        .partial_next (asm_partial)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (load_start) state_nxt = LOAD;
            LOAD:    if (load_end)   state_nxt = FLUSH;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            restart_q <= 1'b0;
            wl_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            restart_q <= (state == FLUSH);
            if (state == RUN && load_start) begin
                wptr  <= '0;
                wl_q  <= '0;
                err_q <= 1'b0;
            end
            if (in_load) begin
                if (asm_word_valid) begin
                    wdata_q <= asm_word;
                    waddr_q <= wptr;
                    we_q    <= 1'b1;
                    wptr    <= wptr + 1'b1;
                    // A full count means this write wraps onto word 0.
                    if (wl_q == WL_MAX) err_q <= 1'b1;
                    else                wl_q  <= wl_q + 1'b1;
                end
                if (load_end && asm_partial) err_q <= 1'b1;
            end
        end
    end

    assign mem_addr     = (state == RUN) ? pc[INSTR_ADDR_BITS+1:2] : waddr_q;
    assign mem_wdata    = wdata_q;
    assign mem_we       = we_q;
    assign instruction  = (state == RUN) ? mem_rdata : 32'd0;
    assign cpu_stall    = (state != RUN);
    assign cpu_restart  = restart_q;
    assign words_loaded = wl_q;
    assign load_err     = err_q;

endmodule

// File: tb/tb_imem_load_controller.sv
// Scoreboard bench for imem_load_controller with a behavioural memory.
// Expected writes are queued at issue and checked by a negedge monitor.
module tb_imem_load_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        cpu_stall;
    logic        cpu_restart;
    logic        load_start;
    logic        load_end;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [5:0]  words_loaded;
    logic        load_err;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [32];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    imem_load_controller #(.INSTR_ADDR_BITS(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .cpu_stall    (cpu_stall),
        .cpu_restart  (cpu_restart),
        .load_start   (load_start),
        .load_end     (load_end),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .words_loaded (words_loaded),
        .load_err     (load_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every memory write must match the head of the queue.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", {27'd0, mem_addr}, {27'd0, e.addr});
                check("write_data", mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [4:0] a,
                             input bit end_on_last);
        for (int i = 0; i < 4; i++) begin
            byte_in    = w[8*i +: 8];
            byte_valid = 1'b1;
            if (i == 3) begin
                exp_q.push_back('{addr: a, data: w});
                load_end = end_on_last;
            end
            tick();
        end
        byte_valid = 1'b0;
        load_end   = 1'b0;
    endtask

    task automatic end_load();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    // Called once the FSM is in FLUSH.
    task automatic flush_to_run(input string tag);
        check({tag, "_flush_stall"}, {31'd0, cpu_stall}, 32'd1);
        check({tag, "_flush_norestart"}, {31'd0, cpu_restart}, 32'd0);
        tick();
        check({tag, "_restart_pulse"}, {31'd0, cpu_restart}, 32'd1);
        check({tag, "_run_stall"}, {31'd0, cpu_stall}, 32'd0);
        tick();
        check({tag, "_restart_clear"}, {31'd0, cpu_restart}, 32'd0);
    endtask

    task automatic fetch(input string name, input logic [31:0] a,
                         input logic [31:0] exp);
        pc = a;
        #1;
        check(name, instruction, exp);
        check({name, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        pc         = '0;
        load_start = 1'b0;
        load_end   = 1'b0;
        byte_in    = '0;
        byte_valid = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_restart", {31'd0, cpu_restart}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wl", {26'd0, words_loaded}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);

        // Fetch path, including ignored low bits and address wrap
        fetch("fetch_0", 32'h0, 32'hA000_0000);
        fetch("fetch_4", 32'h4, 32'hA000_0001);
        fetch("fetch_7", 32'h7, 32'hA000_0001);
        fetch("fetch_7c", 32'h7C, 32'hA000_001F);
        fetch("fetch_80", 32'h80, 32'hA000_0000);

        // RUN ignores bytes and load_end
        byte_valid = 1'b1;
        load_end   = 1'b1;
        byte_in    = 8'h55;
        tick();
        byte_valid = 1'b0;
        load_end   = 1'b0;
        check("run_ignore_stall", {31'd0, cpu_stall}, 32'd0);

        // Two-word load
        begin_load();
        check("load_stall", {31'd0, cpu_stall}, 32'd1);
        check("load_instr_zero", instruction, 32'd0);
        send_word(32'h0000_0013, 5'd0, 1'b0);
        send_word(32'h0010_0093, 5'd1, 1'b0);
        end_load();
        flush_to_run("two");
        check("two_wl", {26'd0, words_loaded}, 32'd2);
        check("two_err", {31'd0, load_err}, 32'd0);
        fetch("two_fetch0", 32'h0, 32'h0000_0013);
        fetch("two_fetch1", 32'h4, 32'h0010_0093);

        // Six bytes: partial word discarded
        begin_load();
        check("six_clear_wl", {26'd0, words_loaded}, 32'd0);
        send_word(32'h0403_0201, 5'd0, 1'b0);
        send_byte(8'h05);
        send_byte(8'h06);
        end_load();
        flush_to_run("six");
        check("six_wl", {26'd0, words_loaded}, 32'd1);
        check("six_err", {31'd0, load_err}, 32'd1);
        fetch("six_fetch1", 32'h4, 32'h0010_0093);

        // 33 words: last one wraps onto address 0
        begin_load();
        check("ovf_err_cleared", {31'd0, load_err}, 32'd0);
        for (int k = 0; k < 33; k++) begin
            send_word(32'hC0DE_0000 + k, 5'(k), 1'b0);
            if (k == 31) begin
                check("ovf_wl_32", {26'd0, words_loaded}, 32'd32);
                check("ovf_err_32", {31'd0, load_err}, 32'd0);
            end
        end
        end_load();
        flush_to_run("ovf");
        check("ovf_wl", {26'd0, words_loaded}, 32'd32);
        check("ovf_err", {31'd0, load_err}, 32'd1);
        fetch("ovf_fetch0", 32'h0, 32'hC0DE_0020);
        fetch("ovf_fetch31", 32'h7C, 32'hC0DE_001F);

        // Fourth byte coincident with load_end
        begin_load();
        send_word(32'hDEAD_BEEF, 5'd0, 1'b1);
        flush_to_run("coin");
        check("coin_wl", {26'd0, words_loaded}, 32'd1);
        check("coin_err", {31'd0, load_err}, 32'd0);
        fetch("coin_fetch0", 32'h0, 32'hDEAD_BEEF);

        // Reset in the middle of the third word
        begin_load();
        send_word(32'h1122_3344, 5'd0, 1'b0);
        send_word(32'h5566_7788, 5'd1, 1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'hCC;
            tick();
            check("mid_rst_restart", {31'd0, cpu_restart}, 32'd0);
            check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        end
        byte_valid = 1'b0;
        fetch("mid_fetch0", 32'h0, 32'h1122_3344);
        fetch("mid_fetch1", 32'h4, 32'h5566_7788);
        fetch("mid_fetch2", 32'h8, 32'hC0DE_0002);

        tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
